prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 28 ++
 rtl/prog_loader_word_assembler.sv | 44 ++++
 rtl/prog_loader.sv | 141 ++++++++++++++
 tb/tb_prog_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
// Holds the loader state encoding, the default instruction-memory
// word-address width and the byte order used when packing received
// bytes into 32-bit instruction words.
package prog_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } load_state_t;

    // Word address width of the instruction memory (PC[15:2]).
    localparam int ADDR_W_DEFAULT = 14;

    // First received byte lands in bits 31:24 when set.
    localparam bit BYTE_ORDER_BIG = 1'b1;

    // Bit offset of the byte lane that byte number idx occupies.
    function automatic logic [4:0] byte_lane(input logic [1:0] idx);
        if (BYTE_ORDER_BIG) begin
            return 5'd24 - {idx, 3'b000};
        end
        return {idx, 3'b000};
    endfunction

endpackage

// File: rtl/prog_loader_word_assembler.sv
// word_assembler: packs a stream of bytes into 32-bit words.
// Ports:
//   clock, reset   - clock and synchronous active-high reset
//   clear          - restart at byte 0 (new load session)
//   byte_in        - byte to store
//   byte_valid     - store byte_in into the current lane this cycle
//   index          - lane the next byte will be written to
//   word           - assembled word register
//   full           - the byte being stored this cycle completes a word
module word_assembler
    import prog_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic [1:0]  index,
    output logic [31:0] word,
    output logic        full
);

    logic [1:0]  idx_r;
    logic [31:0] word_r;

    always_ff @(posedge clock) begin
        if (reset) begin
            idx_r  <= 2'd0;
            word_r <= 32'd0;
        end else if (clear) begin
            idx_r <= 2'd0;
        end else if (byte_valid) begin
            word_r[byte_lane(idx_r) +: 8] <= byte_in;
            // Natural 2-bit wrap puts the index back at lane 0 after
            // the fourth byte, ready for a byte arriving in WRITE.
            idx_r <= idx_r + 2'd1;
        end
    end

    assign index = idx_r;
    assign word  = word_r;
    assign full  = byte_valid && (idx_r == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// prog_loader: loads a program received over a UART byte stream into
// the instruction memory through its second (write) port, holding the
// CPU fetch stage in reset while loading.
// Ports:
//   clock, reset  - clock and synchronous active-high reset
//   start         - one-cycle pulse requesting a load session
//   rx_byte       - received byte, qualified by rx_valid
//   rx_valid      - one-cycle strobe for rx_byte
//   mem_we        - instruction-memory write enable
//   mem_addr      - word address (PC[15:2] indexing)
//   mem_wdata     - instruction word being written
//   cpu_reset     - reset to fetch stage / PC register
//   busy          - session active
//   done          - session finished, until next start or reset
//   err           - session ended with a partial word (valid while done)
//   word_count    - words written in the current or last session
//
// state    | meaning
// ---------+-----------------------------------------------------
// ST_IDLE  | no session since reset; waiting for start
// ST_RECV  | collecting bytes, idle timer running
// ST_WRITE | one-cycle write of the assembled word
// ST_DONE  | session ended; waiting for start
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEFAULT,
    parameter int IDLE_CYCLES = 100000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam int IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);

    load_state_t       state;
    logic [IDLE_W-1:0] idle_cnt;
    logic              addr_last;
    logic              session_start;
    logic              accept;
    logic [1:0]        asm_index;
    logic [31:0]       asm_word;
    logic              asm_full;

    assign addr_last     = &mem_addr;
    assign session_start = start && ((state == ST_IDLE) || (state == ST_DONE));
    // A byte arriving during WRITE starts the next word, unless this
    // write fills the last address and the session is about to end.
    assign accept        = rx_valid &&
                           ((state == ST_RECV) || ((state == ST_WRITE) && !addr_last));

    word_assembler u_word_assembler (
        .clock      (clock),
        .reset      (reset),
        .clear      (session_start),
        .byte_in    (rx_byte),
        .byte_valid (accept),
        .index      (asm_index),
        .word       (asm_word),
        .full       (asm_full)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            word_count <= '0;
            idle_cnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_RECV;
                        mem_addr   <= '0;
                        word_count <= '0;
                        idle_cnt   <= '0;
                        err        <= 1'b0;
                        done       <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                ST_RECV: begin
                    if (rx_valid) begin
                        idle_cnt <= '0;
                        if (asm_full) begin
                            state  <= ST_WRITE;
                            mem_we <= 1'b1;
                        end
                    end else if (idle_cnt == IDLE_LAST) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        err   <= (asm_index != 2'd0);
                    end else begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end
                ST_WRITE: begin
                    mem_we     <= 1'b0;
                    word_count <= word_count + (ADDR_W + 1)'(1);
                    if (rx_valid) begin
                        idle_cnt <= '0;
                    end
                    if (addr_last) begin
                        // Memory full: end here rather than wrap onto word 0.
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        err   <= 1'b0;
                    end else begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                        state    <= ST_RECV;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_wdata = asm_word;
    assign cpu_reset = reset | busy;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_a;
    logic        start_b;
    logic [7:0]  rx_byte;
    logic        rx_valid;

    logic        mem_we_a, cpu_reset_a, busy_a, done_a, err_a;
    logic [13:0] mem_addr_a;
    logic [31:0] mem_wdata_a;
    logic [14:0] word_count_a;

    logic        mem_we_b, cpu_reset_b, busy_b, done_b, err_b;
    logic [1:0]  mem_addr_b;
    logic [31:0] mem_wdata_b;
    logic [2:0]  word_count_b;

    int errors = 0;
    int checks = 0;

    logic [45:0] q_a[$];
    logic [33:0] q_b[$];

    always #5 clock = ~clock;

    prog_loader #(.ADDR_W(14), .IDLE_CYCLES(16)) dut_a (
        .clock(clock), .reset(reset), .start(start_a),
        .rx_byte(rx_byte), .rx_valid(rx_valid),
        .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .cpu_reset(cpu_reset_a), .busy(busy_a), .done(done_a), .err(err_a),
        .word_count(word_count_a)
    );

    prog_loader #(.ADDR_W(2), .IDLE_CYCLES(16)) dut_b (
        .clock(clock), .reset(reset), .start(start_b),
        .rx_byte(rx_byte), .rx_valid(rx_valid),
        .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .cpu_reset(cpu_reset_b), .busy(busy_b), .done(done_b), .err(err_b),
        .word_count(word_count_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Write monitors: every mem_we cycle must match the oldest expected write.
    always @(negedge clock) begin
        logic [45:0] e;
        if (mem_we_a === 1'b1) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL write_a unexpected actual=%0h required=none", {mem_addr_a, mem_wdata_a});
            end else begin
                e = q_a.pop_front();
                if ({mem_addr_a, mem_wdata_a} !== e) begin
                    errors++;
                    $display("FAIL write_a actual=%0h required=%0h", {mem_addr_a, mem_wdata_a}, e);
                end
            end
        end
    end

    always @(negedge clock) begin
        logic [33:0] e;
        if (mem_we_b === 1'b1) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL write_b unexpected actual=%0h required=none", {mem_addr_b, mem_wdata_b});
            end else begin
                e = q_b.pop_front();
                if ({mem_addr_b, mem_wdata_b} !== e) begin
                    errors++;
                    $display("FAIL write_b actual=%0h required=%0h", {mem_addr_b, mem_wdata_b}, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24], 1);
        send_byte(w[23:16], 1);
        send_byte(w[15:8], 1);
        send_byte(w[7:0], 1);
    endtask

    task automatic wait_done_a(input string name, output int cycles);
        cycles = 0;
        while (done_a !== 1'b1 && cycles < 100) begin
            tick();
            cycles++;
        end
        check({name, "_done"}, 64'(done_a), 64'd1);
    endtask

    initial begin
        int cyc;
        reset    = 1'b1;
        start_a  = 1'b0;
        start_b  = 1'b0;
        rx_byte  = 8'h00;
        rx_valid = 1'b0;
        tick();
        tick();
        // reset state
        check("reset_outs", {mem_we_a, busy_a, done_a, err_a, mem_addr_a, mem_wdata_a, word_count_a},
              64'd0);
        check("reset_cpu_reset", 64'(cpu_reset_a), 64'd1);
        reset = 1'b0;
        tick();
        check("idle_cpu_reset", 64'(cpu_reset_a), 64'd0);

        // single word
        pulse_start_a();
        check("start_busy", {busy_a, cpu_reset_a, done_a}, 64'b110);
        q_a.push_back({14'd0, 32'h3C080010});
        send_word(32'h3C080010);
        check("one_word_count", 64'(word_count_a), 64'd1);
        wait_done_a("one_word", cyc);
        check("one_word_end", {err_a, busy_a, cpu_reset_a, 15'(word_count_a)}, {3'b000, 15'd1});

        // bytes in DONE are ignored
        send_word(32'hDEADBEEF);
        check("done_ignores_rx", {done_a, 15'(word_count_a)}, {1'b1, 15'd1});

        // two words, with a start pulse mid-session that must be ignored
        pulse_start_a();
        q_a.push_back({14'd0, 32'h11223344});
        q_a.push_back({14'd1, 32'h55667788});
        send_word(32'h11223344);
        pulse_start_a();
        check("start_ignored", {busy_a, 15'(word_count_a)}, {1'b1, 15'd1});
        send_word(32'h55667788);
        wait_done_a("two_words", cyc);
        check("two_words_end", {err_a, cpu_reset_a, 15'(word_count_a)}, {2'b00, 15'd2});

        // partial word at timeout
        pulse_start_a();
        q_a.push_back({14'd0, 32'hA1A2A3A4});
        send_word(32'hA1A2A3A4);
        send_byte(8'hB1, 1);
        send_byte(8'hB2, 1);
        wait_done_a("partial", cyc);
        check("partial_end", {err_a, 15'(word_count_a)}, {1'b1, 15'd1});

        // byte arriving during the WRITE cycle
        pulse_start_a();
        q_a.push_back({14'd0, 32'h01020304});
        q_a.push_back({14'd1, 32'hAABBCCDD});
        send_byte(8'h01, 1);
        send_byte(8'h02, 1);
        send_byte(8'h03, 1);
        send_byte(8'h04, 0);
        check("in_write", 64'(mem_we_a), 64'd1);
        send_byte(8'hAA, 1);
        send_byte(8'hBB, 1);
        send_byte(8'hCC, 1);
        send_byte(8'hDD, 1);
        wait_done_a("write_overlap", cyc);
        check("write_overlap_end", {err_a, 15'(word_count_a)}, {1'b0, 15'd2});

        // empty session: timeout after exactly 16 quiet cycles
        pulse_start_a();
        wait_done_a("empty", cyc);
        check("empty_timeout_cycles", 64'(cyc), 64'd16);
        check("empty_end", {err_a, 15'(word_count_a)}, {1'b0, 15'd0});

        // small memory on dut_b: fills and stops at the last address
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        q_b.push_back({2'd0, 32'h10111213});
        q_b.push_back({2'd1, 32'h14151617});
        q_b.push_back({2'd2, 32'h18191A1B});
        q_b.push_back({2'd3, 32'h1C1D1E1F});
        for (int i = 0; i < 20; i++) begin
            send_byte(8'(8'h10 + i), 1);
        end
        check("full_end", {done_b, busy_b, err_b, mem_addr_b, word_count_b}, {3'b100, 2'd3, 3'd4});

        // reset mid-session
        pulse_start_a();
        q_a.push_back({14'd0, 32'h21222324});
        q_a.push_back({14'd1, 32'h25262728});
        send_word(32'h21222324);
        send_word(32'h25262728);
        send_byte(8'h29, 1);
        send_byte(8'h2A, 1);
        reset = 1'b1;
        tick();
        check("abort_outs", {mem_we_a, busy_a, done_a, err_a, mem_addr_a, mem_wdata_a, word_count_a},
              64'd0);
        check("abort_cpu_reset", 64'(cpu_reset_a), 64'd1);
        reset = 1'b0;
        repeat (4) tick();
        check("after_abort", {busy_a, done_a, cpu_reset_a}, 64'd0);
        pulse_start_a();
        q_a.push_back({14'd0, 32'h31323334});
        send_word(32'h31323334);
        wait_done_a("restart", cyc);
        check("restart_end", {err_a, 15'(word_count_a)}, {1'b0, 15'd1});

        repeat (3) tick();
        check("queue_a_empty", 64'(q_a.size()), 64'd0);
        check("queue_b_empty", 64'(q_b.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
